// File: rtl/enc_vtp.sv
// enc_vtp: programming side of the virtual-to-physical decoder.
// Owns the per-stage switch-control-bit (SCB) array, and walks one address bit
// per cycle to serve three commands:
//   MAP   : write the SCBs so that vaddr translates to paddr
//   QUERY : read back the current translation of vaddr
//   CLEAR : zero the whole array
// Translation rule: paddr[b] = vaddr[b] ^ scb[b][vaddr >> (b+1)].
// Optional feature macro: ENC_VTP_LOCK_EN. When it is defined, every
// committed SCB is locked, and a MAP that would flip a locked bit is rejected
// as a whole with o_rsp_err = 1. When it is undefined, there is no lock
// storage, a MAP always commits, and o_rsp_err is tied low.

module enc_vtp #(
  parameter int BITMAP = 128
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_req_valid,
  output logic                                  o_req_ready,
  input  logic [1:0]                            i_req_op,
  input  logic [$clog2(BITMAP)-1:0]             i_vaddr,
  input  logic [$clog2(BITMAP)-1:0]             i_paddr,
  output logic                                  o_rsp_valid,
  output logic                                  o_rsp_err,
  output logic [$clog2(BITMAP)-1:0]             o_rsp_paddr,
  output logic [$clog2(BITMAP)-1:0][BITMAP/2-1:0] o_scb
);

  localparam int ADDR_W = $clog2(BITMAP);
  localparam int STAGES = $clog2(BITMAP);
  localparam int NODES  = BITMAP / 2;
  localparam int NODE_W = ADDR_W - 1;       // log2(NODES)
  localparam int SEL_W  = $clog2(STAGES);   // selects one stage / address bit

  localparam logic [1:0] OP_MAP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_RESP
  } state_e;

  state_e state_q, state_d;

  // Request fields captured at the handshake.
  logic              map_q;
  logic [ADDR_W-1:0] vaddr_q;
  logic [ADDR_W-1:0] paddr_q;

  // Walk registers.
  logic [SEL_W-1:0]               bit_q;
  logic [ADDR_W-1:0]              res_q;
  logic [STAGES-1:0][NODE_W-1:0]  pend_node_q;
  logic [STAGES-1:0]              pend_val_q;

  // SCB storage and response registers.
  logic [STAGES-1:0][NODES-1:0]   scb_q;
  logic [ADDR_W-1:0]              rsp_paddr_q;

`ifdef ENC_VTP_LOCK_EN
  logic [STAGES-1:0][NODES-1:0]   lock_q;
  logic                           conflict_q;
  logic                           rsp_err_q;
`endif

  // Walk datapath signals.
  logic                           req_go;
  logic                           clear_go;
  logic                           last_bit;
  logic [NODE_W-1:0]              node;
  logic                           cur_scb;
  logic                           need;
  logic                           hit_conflict;
  logic                           conflict_any;
  logic                           commit;
  logic [ADDR_W-1:0]              res_now;
  logic [STAGES-1:0][NODE_W-1:0]  cnode;
  logic [STAGES-1:0]              cval;

  assign req_go   = (state_q == ST_IDLE) && i_req_valid;
  assign clear_go = req_go && (i_req_op == OP_CLEAR);
  assign last_bit = (bit_q == '0);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every always_ff sees the pre-edge values of the others regardless of order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> WALK/RESP, WALK -> RESP on the last bit, RESP -> IDLE.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          state_d = (i_req_op == OP_CLEAR) ? ST_RESP : ST_WALK;
        end
      end
      ST_WALK: begin
        if (last_bit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    o_req_ready = (state_q == ST_IDLE);
    o_rsp_valid = (state_q == ST_RESP);
  end

  // Per-bit walk: node lookup, needed SCB value, conflict test, query result
  // and the commit vector (current stage from this cycle, others pending).
  always_comb begin
    node    = vaddr_q[ADDR_W-1:1] >> bit_q;
    cur_scb = scb_q[bit_q][node];
    need    = vaddr_q[bit_q] ^ paddr_q[bit_q];
`ifdef ENC_VTP_LOCK_EN
    hit_conflict = map_q && lock_q[bit_q][node] && (cur_scb != need);
    conflict_any = conflict_q || hit_conflict;
`else
    hit_conflict = 1'b0;
    conflict_any = 1'b0;
`endif
    commit          = (state_q == ST_WALK) && last_bit && map_q && !conflict_any;
    res_now         = res_q;
    res_now[bit_q]  = cur_scb ^ vaddr_q[bit_q];
    for (int s = 0; s < STAGES; s++) begin
      if (SEL_W'(s) == bit_q) begin
        cnode[s] = node;
        cval[s]  = need;
      end else begin
        cnode[s] = pend_node_q[s];
        cval[s]  = pend_val_q[s];
      end
    end
  end

  // Request capture and walk bookkeeping (bit counter, result, pending writes).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      map_q       <= 1'b0;
      vaddr_q     <= '0;
      paddr_q     <= '0;
      bit_q       <= '0;
      res_q       <= '0;
      pend_node_q <= '0;
      pend_val_q  <= '0;
    end else begin
      if (req_go && !clear_go) begin
        map_q   <= (i_req_op == OP_MAP);
        vaddr_q <= i_vaddr;
        paddr_q <= i_paddr;
        bit_q   <= SEL_W'(STAGES - 1);
        res_q   <= '0;
      end else if (state_q == ST_WALK) begin
        res_q <= res_now;
        if (map_q && !hit_conflict) begin
          pend_node_q[bit_q] <= node;
          pend_val_q[bit_q]  <= need;
        end
        if (!last_bit) begin
          bit_q <= bit_q - 1'b1;
        end
      end
    end
  end

`ifdef ENC_VTP_LOCK_EN
  // Sticky conflict flag for the current MAP walk.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      conflict_q <= 1'b0;
    end else if (req_go) begin
      conflict_q <= 1'b0;
    end else if (state_q == ST_WALK) begin
      conflict_q <= conflict_any;
    end
  end

  // Lock array: set alongside each committed SCB, cleared by CLEAR or reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lock_q <= '0;
    end else if (clear_go) begin
      lock_q <= '0;
    end else if (commit) begin
      for (int s = 0; s < STAGES; s++) begin
        lock_q[s][cnode[s]] <= 1'b1;
      end
    end
  end
`endif

  // SCB array: all-or-nothing commit on the last walk edge, zeroed by CLEAR.
  // NOTE: this storage is reset explicitly because the decoder consumes it
  // directly and an identity translation is required straight out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scb_q <= '0;
    end else if (clear_go) begin
      scb_q <= '0;
    end else if (commit) begin
      for (int s = 0; s < STAGES; s++) begin
        scb_q[s][cnode[s]] <= cval[s];
      end
    end
  end

  // Response payload, loaded when entering RESP and held until the next one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp_paddr_q <= '0;
    end else if (clear_go) begin
      rsp_paddr_q <= '0;
    end else if ((state_q == ST_WALK) && last_bit) begin
      // A successful MAP makes vaddr translate to paddr; otherwise report
      // the translation through the array as it stands.
      rsp_paddr_q <= (map_q && !conflict_any) ? paddr_q : res_now;
    end
  end

`ifdef ENC_VTP_LOCK_EN
  // Conflict status for the response.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (clear_go) begin
      rsp_err_q <= 1'b0;
    end else if ((state_q == ST_WALK) && last_bit) begin
      rsp_err_q <= map_q && conflict_any;
    end
  end
  assign o_rsp_err = rsp_err_q;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_rsp_paddr = rsp_paddr_q;
  assign o_scb       = scb_q;

endmodule

// File: tb/tb_enc_vtp.sv
// Self-checking bench for enc_vtp at BITMAP=8 (3 stages, 4 nodes per stage).
// The reference model keeps the SCB/lock array as plain bit arrays and applies
// the translation rule directly; lock behaviour follows ENC_VTP_LOCK_EN.

module tb_enc_vtp;

  localparam int BITMAP = 8;
  localparam int AW     = 3;
  localparam int NSTG   = 3;
  localparam int NND    = 4;

`ifdef ENC_VTP_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [1:0]                req_op = 2'b00;
  logic [AW-1:0]             vaddr = '0;
  logic [AW-1:0]             paddr = '0;
  logic                      rsp_valid;
  logic                      rsp_err;
  logic [AW-1:0]             rsp_paddr;
  logic [NSTG-1:0][NND-1:0]  scb;

  int total = 0;
  int bad   = 0;

  // Reference state.
  bit m_scb  [NSTG][NND];
  bit m_lock [NSTG][NND];

  enc_vtp #(.BITMAP(BITMAP)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_vaddr     (vaddr),
    .i_paddr     (paddr),
    .o_rsp_valid (rsp_valid),
    .o_rsp_err   (rsp_err),
    .o_rsp_paddr (rsp_paddr),
    .o_scb       (scb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void m_clear();
    for (int b = 0; b < NSTG; b++) begin
      for (int n = 0; n < NND; n++) begin
        m_scb[b][n]  = 1'b0;
        m_lock[b][n] = 1'b0;
      end
    end
  endfunction

  function automatic logic [AW-1:0] m_xlate(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) begin
      r[b] = v[b] ^ m_scb[b][int'(v) >> (b + 1)];
    end
    return r;
  endfunction

  function automatic logic [11:0] m_pack();
    logic [11:0] f;
    for (int b = 0; b < NSTG; b++) begin
      for (int n = 0; n < NND; n++) begin
        f[b*NND + n] = m_scb[b][n];
      end
    end
    return f;
  endfunction

  // Applies one command to the model and returns the expected response.
  function automatic void m_cmd(input logic [1:0] op, input logic [AW-1:0] v,
                                input logic [AW-1:0] p,
                                output logic e_err, output logic [AW-1:0] e_pa);
    bit conflict;
    int n;
    e_err = 1'b0;
    e_pa  = '0;
    if (op == 2'b10) begin
      m_clear();
    end else if (op == 2'b00) begin
      conflict = 1'b0;
      for (int b = 0; b < AW; b++) begin
        n = int'(v) >> (b + 1);
        if (LOCK_EN && m_lock[b][n] && (m_scb[b][n] != (v[b] ^ p[b]))) conflict = 1'b1;
      end
      if (!conflict) begin
        for (int b = 0; b < AW; b++) begin
          n = int'(v) >> (b + 1);
          m_scb[b][n]  = v[b] ^ p[b];
          m_lock[b][n] = 1'b1;
        end
      end
      e_err = conflict;
      e_pa  = m_xlate(v);
    end else begin
      e_pa = m_xlate(v);
    end
  endfunction

  // Issues one command, measures response latency and checks the payload,
  // the array, and that ready returns with no second response.
  // With poke set, i_req_valid is pulsed during the walk; it must be ignored.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [AW-1:0] v,
                         input logic [AW-1:0] p, input bit poke);
    logic          e_err;
    logic [AW-1:0] e_pa;
    int            lat;
    int            want_lat;
    @(negedge clk);
    check({tag, ".ready_in"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    vaddr     = v;
    paddr     = p;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    m_cmd(op, v, p, e_err, e_pa);
    want_lat = (op == 2'b10) ? 1 : NSTG + 1;
    lat = 0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      if (poke && c == 2) begin
        req_valid = 1'b1;
        req_op    = 2'($urandom_range(0, 3));
        vaddr     = AW'($urandom_range(0, 7));
        paddr     = AW'($urandom_range(0, 7));
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) lat = c;
    end
    req_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(want_lat));
    if (lat != 0) begin
      check({tag, ".err"},   32'(rsp_err),   32'(e_err));
      check({tag, ".paddr"}, 32'(rsp_paddr), 32'(e_pa));
      check({tag, ".scb"},   32'(scb),       32'(m_pack()));
    end
    @(negedge clk);
    check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
    check({tag, ".no_extra"},   32'(rsp_valid), 32'd0);
  endtask

  // Starts a MAP, pulls reset low during the walk and checks the aftermath.
  task automatic reset_mid_map(input logic [AW-1:0] v, input logic [AW-1:0] p);
    int seen;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    vaddr     = v;
    paddr     = p;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);                // cycle T+1
    if (rsp_valid) seen++;
    @(negedge clk);                // cycle T+2: reset asserted
    if (rsp_valid) seen++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    check("rst.scb_zero", 32'(scb), 32'd0);
    @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("rst.no_rsp", 32'(seen), 32'd0);
    check("rst.scb_still_zero", 32'(scb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op;
    int         r;
    m_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.ready",     32'(req_ready), 32'd1);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.rsp_err",   32'(rsp_err),   32'd0);
    check("reset.rsp_paddr", 32'(rsp_paddr), 32'd0);
    check("reset.scb",       32'(scb),       32'd0);

    // Identity translation out of reset.
    run_cmd("q5", 2'b01, 3'd5, 3'd0, 1'b0);

    // MAP 3->6 and its effect on individual bits and other translations.
    run_cmd("map3to6", 2'b00, 3'd3, 3'd6, 1'b0);
    check("map3to6.scb20", 32'(scb[2][0]), 32'd1);
    check("map3to6.scb10", 32'(scb[1][0]), 32'd0);
    check("map3to6.scb01", 32'(scb[0][1]), 32'd1);
    run_cmd("q3", 2'b01, 3'd3, 3'd0, 1'b0);
    run_cmd("q4", 2'b01, 3'd4, 3'd0, 1'b0);

    // Overlapping MAP: rejected with locks, overwrites without.
    run_cmd("map1to1", 2'b00, 3'd1, 3'd1, 1'b0);
    run_cmd("remap3to6", 2'b00, 3'd3, 3'd6, 1'b0);
    run_cmd("q3b", 2'b11, 3'd3, 3'd0, 1'b0);

    // CLEAR then a fresh MAP.
    run_cmd("clear", 2'b10, 3'd0, 3'd0, 1'b0);
    run_cmd("map1to1b", 2'b00, 3'd1, 3'd1, 1'b0);

    // Reset during a walk, then a query with valid pulsed mid-walk.
    reset_mid_map(3'd6, 3'd2);
    run_cmd("poke_q", 2'b01, 3'd6, 3'd0, 1'b1);
    run_cmd("poke_map", 2'b00, 3'd2, 3'd7, 1'b1);

    // Randomized command mix.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      op = 2'b10;
      else if (r < 6)  op = 2'b00;
      else if (r == 9) op = 2'b11;
      else             op = 2'b01;
      run_cmd("rand", op, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
